// File: rtl/clock_time_ctrl_pkg.sv
// rtl/clock_time_ctrl_pkg.sv - shared states, field limits and blink-mask helper for the clock controller
package clock_time_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_SET_H = 2'd1,
        S_SET_M = 2'd2,
        S_SET_S = 2'd3
    } set_state_e;

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    // Bit order matches field_blank: [2] hour, [1] minute, [0] second.
    function automatic logic [2:0] field_onehot(input set_state_e s);
        case (s)
            S_SET_H: field_onehot = 3'b100;
            S_SET_M: field_onehot = 3'b010;
            S_SET_S: field_onehot = 3'b001;
            default: field_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/clock_time_ctrl_mod_counter.sv
// rtl/clock_time_ctrl_mod_counter.sv - modulo-(MAX+1) field counter with inc/dec and cascade carry
module mod_counter
    import clock_time_ctrl_pkg::*;
#(
    parameter logic [5:0] MAX = SEC_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       carry_in,
    output logic [5:0] value,
    output logic       carry_out
);

    logic [5:0] value_q;
    logic [5:0] value_d;
    logic       up;

    always_comb begin
        up      = inc | carry_in;
        value_d = value_q;
        if (up && !dec) begin
            value_d = (value_q == MAX) ? 6'd0 : value_q + 6'd1;
        end else if (dec && !up) begin
            value_d = (value_q == 6'd0) ? MAX : value_q - 6'd1;
        end
    end

    // Carry only follows the cascade input, so edits never ripple into the next field.
    assign carry_out = carry_in && (value_q == MAX);
    assign value     = value_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= 6'd0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - hh:mm:ss timekeeping with key-driven setting FSM and field blink mask
module clock_time_ctrl
    import clock_time_ctrl_pkg::*;
#(
    parameter logic [25:0] CNT_1S_MAX = 26'd49_999_999,
    parameter logic [23:0] BLINK_MAX  = 24'd12_499_999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_dec,
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] set_state,
    output logic [2:0] field_blank,
    output logic       sec_tick
);

    set_state_e  state_q, state_d;
    logic [25:0] cnt_1s_q, cnt_1s_d;
    logic [23:0] blink_cnt_q, blink_cnt_d;
    logic        blink_phase_q, blink_phase_d;
    logic [2:0]  field_blank_q, field_blank_d;
    logic        sec_tick_q, sec_tick_d;

    logic        tick;
    logic        edit, edit_inc, edit_dec;
    logic        sec_carry, min_carry, day_wrap_unused;

    always_comb begin
        state_d = state_q;
        if (key_mode) begin
            case (state_q)
                S_RUN:   state_d = S_SET_H;
                S_SET_H: state_d = S_SET_M;
                S_SET_M: state_d = S_SET_S;
                default: state_d = S_RUN;
            endcase
        end

        tick     = (state_q == S_RUN) && (cnt_1s_q == CNT_1S_MAX);
        edit     = (state_q != S_RUN) && !key_mode && (key_inc ^ key_dec);
        edit_inc = edit && key_inc;
        edit_dec = edit && key_dec;

        // Held at zero through setting and on the exit edge, so RUN restarts a full period.
        if ((state_q != S_RUN) || (state_d != S_RUN) || tick) begin
            cnt_1s_d = 26'd0;
        end else begin
            cnt_1s_d = cnt_1s_q + 26'd1;
        end

        if ((state_d == S_RUN) || (state_d != state_q) || edit) begin
            blink_cnt_d   = 24'd0;
            blink_phase_d = 1'b1;
        end else if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d   = 24'd0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + 24'd1;
            blink_phase_d = blink_phase_q;
        end

        field_blank_d = field_onehot(state_q) & {3{~blink_phase_q}};
        sec_tick_d    = tick;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RUN;
            cnt_1s_q      <= 26'd0;
            blink_cnt_q   <= 24'd0;
            blink_phase_q <= 1'b1;
            field_blank_q <= 3'b000;
            sec_tick_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_1s_q      <= cnt_1s_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            field_blank_q <= field_blank_d;
            sec_tick_q    <= sec_tick_d;
        end
    end

    mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk       (clk),
        .rst       (rst),
        .inc       (edit_inc && (state_q == S_SET_S)),
        .dec       (edit_dec && (state_q == S_SET_S)),
        .carry_in  (tick),
        .value     (second),
        .carry_out (sec_carry)
    );

    mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk       (clk),
        .rst       (rst),
        .inc       (edit_inc && (state_q == S_SET_M)),
        .dec       (edit_dec && (state_q == S_SET_M)),
        .carry_in  (sec_carry),
        .value     (minute),
        .carry_out (min_carry)
    );

    mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk       (clk),
        .rst       (rst),
        .inc       (edit_inc && (state_q == S_SET_H)),
        .dec       (edit_dec && (state_q == S_SET_H)),
        .carry_in  (min_carry),
        .value     (hour),
        .carry_out (day_wrap_unused)
    );

    assign set_state   = state_q;
    assign field_blank = field_blank_q;
    assign sec_tick    = sec_tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - scoreboard bench for clock_time_ctrl with short dividers
module tb_clock_time_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic       key_dec = 1'b0;
    logic [5:0] hour, minute, second;
    logic [1:0] set_state;
    logic [2:0] field_blank;
    logic       sec_tick;

    int errors = 0;
    int checks = 0;

    logic [17:0] exp_time_q[$];
    logic [1:0]  exp_state_q[$];
    logic [2:0]  exp_blank_q[$];

    always #5 clk = ~clk;

    clock_time_ctrl #(
        .CNT_1S_MAX (26'd3),
        .BLINK_MAX  (24'd1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_mode    (key_mode),
        .key_inc     (key_inc),
        .key_dec     (key_dec),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .set_state   (set_state),
        .field_blank (field_blank),
        .sec_tick    (sec_tick)
    );

    task automatic press(input logic m, input logic i, input logic d);
        key_mode = m;
        key_inc  = i;
        key_dec  = d;
        @(posedge clk);
        #1;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        key_dec  = 1'b0;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [2:0] blink_pattern(input int k);
        blink_pattern = (((k - 1) / 2) % 2 == 1) ? 3'b010 : 3'b000;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({hour, minute, second} !== 18'd0)
            $display("FAIL reset_time got=%0d:%0d:%0d exp=0:0:0", hour, minute, second);
        checks++;
        if (set_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", set_state);
        checks++;
        if (field_blank !== 3'b000) $display("FAIL reset_blank got=%b exp=000", field_blank);
        checks++;
        if (sec_tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", sec_tick);
        errors += int'({hour, minute, second} !== 18'd0) + int'(set_state !== 2'd0)
                + int'(field_blank !== 3'b000) + int'(sec_tick !== 1'b0);
    endtask

    task automatic test_run_ticks;
        logic [17:0] e;
        int last;
        last = 0;
        for (int i = 1; i <= 60; i++)
            exp_time_q.push_back((i == 60) ? {6'd0, 6'd1, 6'd0} : {6'd0, 6'd0, 6'(i)});
        rst = 1'b0;
        for (int cyc = 1; cyc <= 300 && exp_time_q.size() > 0; cyc++) begin
            @(posedge clk);
            #1;
            if (sec_tick) begin
                e = exp_time_q.pop_front();
                checks++;
                if ({hour, minute, second} !== e) begin
                    errors++;
                    $display("FAIL run_time got=%0d:%0d:%0d exp=%0d:%0d:%0d",
                             hour, minute, second, e[17:12], e[11:6], e[5:0]);
                end
                checks++;
                if (cyc - last != 4) begin
                    errors++;
                    $display("FAIL tick_period got=%0d exp=4", cyc - last);
                end
                last = cyc;
            end
        end
        checks++;
        if (exp_time_q.size() != 0) begin
            errors++;
            $display("FAIL run_timeout got=%0d pending exp=0", exp_time_q.size());
            exp_time_q.delete();
        end
    endtask

    task automatic test_set_rollover;
        logic [17:0] e;
        bit seen;
        seen = 1'b0;
        pulse_reset();
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        checks++;
        if ({hour, minute, second} !== {6'd23, 6'd59, 6'd59}) begin
            errors++;
            $display("FAIL set_2359 got=%0d:%0d:%0d exp=23:59:59", hour, minute, second);
        end
        press(1, 0, 0);
        checks++;
        if (set_state !== 2'd0) begin
            errors++;
            $display("FAIL exit_state got=%0d exp=0", set_state);
        end
        exp_time_q.push_back(18'd0);
        for (int cyc = 1; cyc <= 10 && !seen; cyc++) begin
            @(posedge clk);
            #1;
            if (sec_tick) begin
                seen = 1'b1;
                e = exp_time_q.pop_front();
                checks++;
                if ({hour, minute, second} !== e) begin
                    errors++;
                    $display("FAIL rollover got=%0d:%0d:%0d exp=0:0:0", hour, minute, second);
                end
                checks++;
                if (cyc != 4) begin
                    errors++;
                    $display("FAIL first_tick_delay got=%0d exp=4", cyc);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rollover_timeout got=no_tick exp=tick");
            exp_time_q.delete();
        end
    endtask

    task automatic test_mode_cycle;
        logic [17:0] frozen;
        logic [1:0]  es;
        bit seen;
        seen = 1'b0;
        frozen = 18'd0;
        for (int cyc = 1; cyc <= 10 && !seen; cyc++) begin
            @(posedge clk);
            #1;
            if (sec_tick) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mode_sync_timeout got=no_tick exp=tick");
        end
        for (int k = 1; k <= 4; k++) begin
            exp_state_q.push_back(2'(k % 4));
            press(1, 0, 0);
            es = exp_state_q.pop_front();
            checks++;
            if (set_state !== es) begin
                errors++;
                $display("FAIL mode_state got=%0d exp=%0d", set_state, es);
            end
            if (k == 1) frozen = {hour, minute, second};
            if (k < 4) begin
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (sec_tick !== 1'b0 || {hour, minute, second} !== frozen) begin
                        errors++;
                        $display("FAIL frozen got=%b %0d:%0d:%0d exp=0 %0d:%0d:%0d", sec_tick,
                                 hour, minute, second, frozen[17:12], frozen[11:6], frozen[5:0]);
                    end
                end
            end else begin
                checks++;
                if ({hour, minute, second} !== frozen) begin
                    errors++;
                    $display("FAIL frozen_exit got=%0d:%0d:%0d exp=%0d:%0d:%0d", hour, minute,
                             second, frozen[17:12], frozen[11:6], frozen[5:0]);
                end
            end
        end
    endtask

    task automatic test_set_fields;
        logic [17:0] e;
        logic [2:0]  stim[7];
        logic [17:0] expv[7];
        stim[0] = 3'b001; expv[0] = {6'd23, 6'd0, 6'd0};
        stim[1] = 3'b010; expv[1] = {6'd0, 6'd0, 6'd0};
        stim[2] = 3'b011; expv[2] = {6'd0, 6'd0, 6'd0};
        stim[3] = 3'b100; expv[3] = {6'd0, 6'd0, 6'd0};
        stim[4] = 3'b001; expv[4] = {6'd0, 6'd59, 6'd0};
        stim[5] = 3'b010; expv[5] = {6'd0, 6'd0, 6'd0};
        stim[6] = 3'b110; expv[6] = {6'd0, 6'd0, 6'd0};
        pulse_reset();
        press(1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            exp_time_q.push_back(expv[i]);
            press(stim[i][2], stim[i][1], stim[i][0]);
            e = exp_time_q.pop_front();
            checks++;
            if ({hour, minute, second} !== e) begin
                errors++;
                $display("FAIL set_field_%0d got=%0d:%0d:%0d exp=%0d:%0d:%0d", i,
                         hour, minute, second, e[17:12], e[11:6], e[5:0]);
            end
        end
        checks++;
        if (set_state !== 2'd3) begin
            errors++;
            $display("FAIL mode_with_inc_state got=%0d exp=3", set_state);
        end
        press(1, 0, 0);
    endtask

    task automatic test_blink;
        logic [2:0] eb;
        pulse_reset();
        press(1, 0, 0);
        press(1, 0, 0);
        for (int k = 0; k <= 13; k++) begin
            if (k == 7) begin
                exp_blank_q.push_back(3'b010);
                press(0, 1, 0);
            end else if (k > 7) begin
                exp_blank_q.push_back(blink_pattern(k - 7));
                @(posedge clk);
                #1;
            end else begin
                exp_blank_q.push_back((k == 0) ? 3'b000 : blink_pattern(k));
                if (k > 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            eb = exp_blank_q.pop_front();
            checks++;
            if (field_blank !== eb) begin
                errors++;
                $display("FAIL blink_%0d got=%b exp=%b", k, field_blank, eb);
            end
        end
        checks++;
        if (minute !== 6'd1) begin
            errors++;
            $display("FAIL blink_inc_minute got=%0d exp=1", minute);
        end
        press(1, 0, 0);
        press(1, 0, 0);
        for (int c = 0; c < 5; c++) begin
            exp_blank_q.push_back(3'b000);
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            eb = exp_blank_q.pop_front();
            checks++;
            if (field_blank !== eb) begin
                errors++;
                $display("FAIL blink_run_%0d got=%b exp=%b", c, field_blank, eb);
            end
        end
    endtask

    task automatic test_async_reset;
        bit seen;
        seen = 1'b0;
        pulse_reset();
        press(1, 0, 0);
        repeat (12) press(0, 1, 0);
        press(1, 0, 0);
        repeat (34) press(0, 1, 0);
        press(1, 0, 0);
        repeat (56) press(0, 1, 0);
        checks++;
        if ({hour, minute, second} !== {6'd12, 6'd34, 6'd56} || set_state !== 2'd3) begin
            errors++;
            $display("FAIL preset got=%0d:%0d:%0d st%0d exp=12:34:56 st3",
                     hour, minute, second, set_state);
        end
        for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
            @(posedge clk);
            #1;
            if (field_blank !== 3'b000) seen = 1'b1;
        end
        checks++;
        if (field_blank !== 3'b001) begin
            errors++;
            $display("FAIL sets_blank got=%b exp=001", field_blank);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({hour, minute, second} !== 18'd0 || set_state !== 2'd0 || field_blank !== 3'b000
            || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got=%0d:%0d:%0d st%0d bl%b tk%b exp=0:0:0 st0 bl000 tk0",
                     hour, minute, second, set_state, field_blank, sec_tick);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_set_rollover();
        test_mode_cycle();
        test_set_fields();
        test_blink();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
